// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: UART receiver with a 2-FF synchroniser, mid-bit sampling
// FSM, optional parity check and a receive FIFO drained by a level drop.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_LENGTH  = 16,
  parameter int COUNTER_SIZE = $clog2(FIFO_LENGTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx,
  output logic [DATA_WIDTH-1:0]   data_o,
  input  logic                    drop,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic [COUNTER_SIZE-1:0] awaiting_count,
  output logic                    busy,
  output logic                    frame_error,
  output logic                    parity_error,
  output logic                    overrun
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam int PTR_W  = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                  state, state_nxt;
  logic                    rx_s1, rx_s2, rx_prev;
  logic                    rx_fall;
  logic [BAUD_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    par_err;
  logic                    half_tick, bit_tick, last_bit;
  logic                    push, do_pop;
  logic [DATA_WIDTH-1:0]   mem [FIFO_LENGTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_LENGTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // rx synchroniser plus one extra stage for falling-edge detection; the edge
  // detector also keeps IDLE from re-arming until rx has been seen high again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall   = rx_prev & ~rx_s2;
  assign half_tick = (baud_cnt == BAUD_W'(CLKS_PER_BIT / 2 - 1));
  assign bit_tick  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rx_fall) state_nxt = S_START;
      S_START:  if (half_tick) state_nxt = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (bit_tick && last_bit) state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_tick) state_nxt = S_STOP;
      S_STOP:   if (bit_tick) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: busy level and the single per-frame verdict on the stop-sample cycle
  always_comb begin
    busy         = (state != S_IDLE);
    frame_error  = 1'b0;
    parity_error = 1'b0;
    overrun      = 1'b0;
    push         = 1'b0;
    if (state == S_STOP && bit_tick) begin
      if (!rx_s2)                 frame_error  = 1'b1;
      else if (par_err)           parity_error = 1'b1;
      else if (fifo_full && !drop) overrun     = 1'b1;
      else                        push         = 1'b1;
    end
  end

  // Bit-timing counters, data shifter (LSB first) and latched parity mismatch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_fall) par_err <= 1'b0;
        end
        S_START: baud_cnt <= half_tick ? '0 : baud_cnt + 1'b1;
        S_DATA: begin
          if (bit_tick) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_s2, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            par_err  <= ((^shift_reg) ^ rx_s2) != 1'(PARITY_ODD);
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP:  baud_cnt <= bit_tick ? '0 : baud_cnt + 1'b1;
        default: baud_cnt <= '0;
      endcase
    end
  end

  // FIFO storage; contents need no reset because data_o is masked while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  assign do_pop = drop & ~fifo_empty;

  // FIFO pointers and occupancy; push with drop leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      awaiting_count <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   awaiting_count <= awaiting_count + 1'b1;
        2'b01:   awaiting_count <= awaiting_count - 1'b1;
        default: awaiting_count <= awaiting_count;
      endcase
    end
  end

  assign fifo_empty = (awaiting_count == '0);
  assign fifo_full  = (awaiting_count == COUNTER_SIZE'(FIFO_LENGTH));
  assign data_o     = fifo_empty ? '0 : mem[rd_ptr];

endmodule
